// File: rtl/fp_div_seq.sv
// Sequential IEEE-754 binary32 divider (OUT = A / B): radix-2 restoring mantissa loop, RNE rounding.
// Define FP_DIV_SUBNORMAL_EN for subnormal inputs/results; otherwise subnormals are flushed to signed zero.
module fp_div_seq #(
  parameter int unsigned ITERS = 27
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        reg_en,
  input  logic        start,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] OUT,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_RND, S_DONE} state_t;

  state_t state, state_nxt;

  logic              sign_q;
  logic signed [9:0] exp_q;
  logic [23:0]       mb_q;
  logic [24:0]       rem_q;
  logic [26:0]       quo_q;
  logic [4:0]        cnt_q;

  // Returns {unbiased exponent, 24-bit mantissa with the leading one at bit 23}.
  function automatic logic [33:0] unpack(input logic [31:0] x);
    logic [23:0]       m;
    logic signed [9:0] e;
    m = {1'b1, x[22:0]};
    e = $signed({2'b00, x[30:23]}) - 10'sd127;
`ifdef FP_DIV_SUBNORMAL_EN
    if (x[30:23] == 8'd0) begin
      m = {1'b0, x[22:0]};
      e = -10'sd126;
      for (int unsigned i = 0; i < 23; i++) begin
        if (!m[23]) begin
          m = m << 1;
          e = e - 10'sd1;
        end
      end
    end
`else
    if (x[30:23] == 8'd0) begin
      m = '0;
    end
`endif
    return {e, m};
  endfunction

  logic signed [9:0] ea, eb, exp_start;
  logic [23:0]       ma, mb;

  assign {ea, ma} = unpack(A);
  assign {eb, mb} = unpack(B);
  assign exp_start = ea - eb + 10'sd127;

  logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, res_sign;
  logic special;
  logic [31:0] special_val;

  assign a_nan = (A[30:23] == 8'hFF) && (A[22:0] != 23'd0);
  assign b_nan = (B[30:23] == 8'hFF) && (B[22:0] != 23'd0);
  assign a_inf = (A[30:23] == 8'hFF) && (A[22:0] == 23'd0);
  assign b_inf = (B[30:23] == 8'hFF) && (B[22:0] == 23'd0);
`ifdef FP_DIV_SUBNORMAL_EN
  assign a_zero = (A[30:23] == 8'd0) && (A[22:0] == 23'd0);
  assign b_zero = (B[30:23] == 8'd0) && (B[22:0] == 23'd0);
`else
  assign a_zero = (A[30:23] == 8'd0);
  assign b_zero = (B[30:23] == 8'd0);
`endif
  assign res_sign = A[31] ^ B[31];

  always_comb begin
    special     = 1'b1;
    special_val = '0;
    if (a_nan || b_nan) begin
      special_val = 32'h7FC0_0000;
    end else if ((a_inf && b_inf) || (a_zero && b_zero)) begin
      special_val = 32'h7FC0_0000;
    end else if (a_inf || b_zero) begin
      special_val = {res_sign, 8'hFF, 23'd0};
    end else if (b_inf || a_zero) begin
      special_val = {res_sign, 31'd0};
    end else begin
      special = 1'b0;
    end
  end

  // One restoring step; the remainder after a successful subtract is below mb, so 24 bits suffice.
  logic        ge;
  logic [23:0] rem_diff;
  logic [24:0] rem_div;

  assign ge       = rem_q >= {1'b0, mb_q};
  assign rem_diff = rem_q[23:0] - mb_q;
  assign rem_div  = ge ? {rem_diff, 1'b0} : {rem_q[23:0], 1'b0};

  logic [26:0]       q_n;
  logic signed [9:0] e_n, e_r;
  logic [23:0]       mant;
  logic              guard, sticky, inc;
  logic [24:0]       sum;
  logic [22:0]       frac;
  logic [31:0]       rnd_result;
`ifdef FP_DIV_SUBNORMAL_EN
  logic              tiny;
  logic [4:0]        sh;
  logic [49:0]       wide;
`endif

  always_comb begin
    q_n = quo_q;
    e_n = exp_q;
    if (!quo_q[26]) begin
      q_n = quo_q << 1;
      e_n = exp_q - 10'sd1;
    end
    mant   = q_n[26:3];
    guard  = q_n[2];
    sticky = (|q_n[1:0]) | (|rem_q);
`ifdef FP_DIV_SUBNORMAL_EN
    tiny = 1'b0;
    sh   = '0;
    wide = '0;
    if (e_n <= 10'sd0) begin
      tiny   = 1'b1;
      sh     = (e_n <= -10'sd25) ? 5'd26 : 5'(10'sd1 - e_n);
      wide   = {mant, guard, 25'd0} >> sh;
      mant   = wide[49:26];
      guard  = wide[25];
      sticky = sticky | (|wide[24:0]);
      e_n    = '0;
    end
`endif
    inc  = guard & (sticky | mant[0]);
    sum  = {1'b0, mant} + {24'd0, inc};
    e_r  = e_n;
    frac = sum[22:0];
    if (sum[24]) begin
      e_r  = e_n + 10'sd1;
      frac = sum[23:1];
    end
    rnd_result = {sign_q, e_r[7:0], frac};
`ifdef FP_DIV_SUBNORMAL_EN
    if (tiny) begin
      rnd_result = {sign_q, 7'd0, sum[23], frac};
    end
`else
    if (e_r <= 10'sd0) begin
      rnd_result = {sign_q, 31'd0};
    end
`endif
    if (e_r >= 10'sd255) begin
      rnd_result = {sign_q, 8'hFF, 23'd0};
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) state_nxt = special ? S_DONE : S_DIV;
      S_DIV:  if (cnt_q == 5'(ITERS - 1)) state_nxt = S_RND;
      S_RND:  state_nxt = S_DONE;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= S_IDLE;
    end else if (reg_en) begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sign_q <= 1'b0;
      exp_q  <= '0;
      mb_q   <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      cnt_q  <= '0;
      OUT    <= '0;
    end else if (reg_en) begin
      case (state)
        S_IDLE: begin
          if (start) begin
            sign_q <= res_sign;
            exp_q  <= exp_start;
            mb_q   <= mb;
            rem_q  <= {1'b0, ma};
            quo_q  <= '0;
            cnt_q  <= '0;
            if (special) OUT <= special_val;
          end
        end
        S_DIV: begin
          rem_q <= rem_div;
          quo_q <= {quo_q[25:0], ge};
          cnt_q <= cnt_q + 5'd1;
        end
        S_RND:   OUT <= rnd_result;
        default: ;
      endcase
    end
  end

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

endmodule
